// File: rtl/fta_ram_responder.sv
// fta_ram_responder: FTA 128-bit bus responder backed by a multi-cycle internal RAM.
package fta_bus_pkg;
  typedef struct packed {
    logic [5:0] core;
    logic [2:0] channel;
    logic [3:0] tranid;
  } fta_tranid_t;
  typedef struct packed {
    logic [4:0]   cmd;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
    fta_tranid_t  tid;
  } fta_cmd_request128_t;
  typedef struct packed {
    logic         ack;
    logic         rty;
    logic         err;
    fta_tranid_t  tid;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;
endpackage

module fta_ram_responder import fta_bus_pkg::*; #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADR   = 32'hFFF00000,
  parameter logic [31:0] ADR_MASK   = 32'hFFF00000,
  parameter int          ACC_CYCLES = 3,
  parameter int          QDEPTH     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  fta_cmd_request128_t  ftas_req,
  output fta_cmd_response128_t ftas_resp
);
  localparam int QW = $clog2(QDEPTH);
  localparam int CW = $clog2(ACC_CYCLES + 1);
  typedef struct packed {
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
    fta_tranid_t  tid;
  } entry_t;
  typedef enum logic {IDLE, ACCESS} state_t;
  entry_t                 q [QDEPTH];
  entry_t                 op;
  logic [QW-1:0]          wr_ptr, rd_ptr;
  logic [QW:0]            count;
  state_t                 state, state_n;
  logic [CW-1:0]          acc, acc_n;
  logic [127:0]           mem [2**DEPTH_LOG2];
  logic                   pend, rty;
  fta_tranid_t            pend_tid, rty_tid;
  logic [31:0]            pend_adr, rty_adr;
  logic [127:0]           pend_dat, line;
  logic                   valid, full, push, reject, pop, fire, ack, unused;
  logic [DEPTH_LOG2-1:0]  idx;
  assign valid  = ftas_req.cyc & ftas_req.stb & ((ftas_req.adr & ADR_MASK) == BASE_ADR);
  // count is a power-of-two range, so its MSB alone means full
  assign full   = count[QW];
  assign push   = valid & ~full;
  assign reject = valid & full;
  assign ack    = pend & ~rty;
  assign fire   = (state == ACCESS) && (acc == '0);
  assign idx    = op.adr[DEPTH_LOG2+3:4];
  assign unused = ^ftas_req.cmd;
  always_comb begin
    line = mem[idx];
    for (int i = 0; i < 16; i++)
      if (op.we & op.sel[i]) line[i*8 +: 8] = op.dat[i*8 +: 8];
  end
  always_comb begin
    state_n = state;
    acc_n   = acc;
    pop     = (state == IDLE) && (count != '0) && !pend;
    if (pop) begin
      state_n = ACCESS;
      acc_n   = CW'(ACC_CYCLES - 1);
    end else if (state == ACCESS) begin
      acc_n   = acc - CW'(1);
      state_n = (acc == '0) ? IDLE : ACCESS;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state  <= IDLE;
      acc    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pend   <= 1'b0;
      rty    <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      wr_ptr <= wr_ptr + QW'(push);
      rd_ptr <= rd_ptr + QW'(pop);
      count  <= count + (QW+1)'(push) - (QW+1)'(pop);
      rty    <= reject;
      pend   <= fire | (pend & ~ack);
    end
  always_ff @(posedge clk_i) begin
    if (push) q[wr_ptr] <= {ftas_req.we, ftas_req.sel, ftas_req.adr, ftas_req.dat, ftas_req.tid};
    if (pop) op <= q[rd_ptr];
    if (reject) begin
      rty_tid <= ftas_req.tid;
      rty_adr <= ftas_req.adr;
    end
    if (fire) begin
      pend_tid <= op.tid;
      pend_adr <= op.adr;
      pend_dat <= line;
      if (op.we) mem[idx] <= line;
    end
  end
  // retry wins the shared response lanes; idle lanes stay zero
  always_comb begin
    ftas_resp     = '0;
    ftas_resp.ack = ack;
    ftas_resp.rty = rty;
    ftas_resp.tid = rty ? rty_tid : ack ? pend_tid : '0;
    ftas_resp.adr = rty ? rty_adr : ack ? pend_adr : '0;
    ftas_resp.dat = ack ? pend_dat : '0;
  end
endmodule

// File: tb/tb_fta_ram_responder.sv
// tb_fta_ram_responder: directed latency scenarios plus a randomized run against a queue-level model.
module tb_fta_ram_responder;
  import fta_bus_pkg::*;
  localparam int ACC = 3;
  localparam int QD  = 4;
  typedef struct {
    bit           we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
    fta_tranid_t  tid;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fta_cmd_request128_t  req;
  fta_cmd_response128_t resp_a, resp_b;
  fta_cmd_request128_t  sched [64];
  fta_cmd_response128_t la [64], lb [64];
  int checks = 0;
  int errors = 0;
  logic [127:0] wd = 128'h0123456789abcdef0123456789abcdef;
  always #5 clk = ~clk;
  fta_ram_responder dut_a (.clk_i(clk), .rst_i(rst), .ftas_req(req), .ftas_resp(resp_a));
  fta_ram_responder #(.QDEPTH(2)) dut_b (.clk_i(clk), .rst_i(rst), .ftas_req(req), .ftas_resp(resp_b));

  function automatic fta_cmd_request128_t mk(bit we, logic [15:0] sel, logic [31:0] adr,
                                             logic [127:0] dat, logic [3:0] tranid);
    fta_cmd_request128_t r = '0;
    r.cyc = 1'b1; r.stb = 1'b1; r.we = we; r.sel = sel; r.adr = adr; r.dat = dat;
    r.tid.core = 6'd5; r.tid.channel = 3'd2; r.tid.tranid = tranid; r.cmd = 5'h1f;
    return r;
  endfunction

  task automatic clear_sched();
    foreach (sched[i]) sched[i] = '0;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_sched();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      la[c] = resp_a;
      lb[c] = resp_b;
      req = sched[c];
    end
  endtask

  task automatic test_reset();
    req = mk(1'b0, '0, 32'hFFF00000, '0, 4'd7);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (resp_a !== '0) begin errors++; $display("FAIL reset_a: resp=%h want 0", resp_a); end
    checks++;
    if (resp_b !== '0) begin errors++; $display("FAIL reset_b: resp=%h want 0", resp_b); end
    do_reset();
  endtask

  task automatic test_write_read();
    int n = 0;
    do_reset();
    sched[0]  = mk(1'b1, 16'hffff, 32'hFFF00010, wd, 4'd1);
    sched[10] = mk(1'b0, 16'h0000, 32'hFFF00010, '0, 4'd2);
    run(20);
    for (int c = 0; c < 20; c++) n += int'(la[c].ack);
    checks++;
    if (n != 2) begin errors++; $display("FAIL wr_ack_count: got %0d want 2", n); end
    checks++;
    if (la[5].ack !== 1'b1 || la[5].tid.tranid !== 4'd1 || la[5].dat !== wd)
      begin errors++; $display("FAIL wr_ack_c5: ack=%b tranid=%0d dat=%h want 1 1 %h", la[5].ack, la[5].tid.tranid, la[5].dat, wd); end
    checks++;
    if (la[15].ack !== 1'b1 || la[15].dat !== wd || la[15].tid !== sched[10].tid || la[15].adr !== 32'hFFF00010)
      begin errors++; $display("FAIL rd_ack_c15: ack=%b tid=%h adr=%h dat=%h want 1 %h fff00010 %h", la[15].ack, la[15].tid, la[15].adr, la[15].dat, sched[10].tid, wd); end
  endtask

  task automatic test_byte_merge();
    do_reset();
    sched[0] = mk(1'b1, 16'hffff, 32'hFFF00020, '0, 4'd1);
    sched[1] = mk(1'b1, 16'h0003, 32'hFFF00020, {{14{8'hCC}}, 16'hBBAA}, 4'd2);
    sched[2] = mk(1'b0, 16'h0000, 32'hFFF00025, '0, 4'd3);
    run(20);
    checks++;
    if (la[10].ack !== 1'b1 || la[10].dat !== 128'hBBAA)
      begin errors++; $display("FAIL merge_wr_c10: ack=%b dat=%h want 1 bbaa", la[10].ack, la[10].dat); end
    checks++;
    if (la[15].ack !== 1'b1 || la[15].dat !== 128'hBBAA || la[15].adr !== 32'hFFF00025 || la[15].tid.tranid !== 4'd3)
      begin errors++; $display("FAIL merge_rd_c15: ack=%b dat=%h adr=%h tranid=%0d want 1 bbaa fff00025 3", la[15].ack, la[15].dat, la[15].adr, la[15].tid.tranid); end
  endtask

  task automatic test_queue_full();
    int na = 0, nr = 0;
    do_reset();
    for (int i = 0; i < 6; i++) sched[i] = mk(1'b0, '0, 32'hFFF00010, '0, 4'(i + 1));
    run(30);
    for (int c = 0; c < 30; c++) begin na += int'(la[c].ack); nr += int'(la[c].rty); end
    checks++;
    if (na != 5 || nr != 1) begin errors++; $display("FAIL qfull_counts: acks=%0d rtys=%0d want 5 1", na, nr); end
    checks++;
    if (la[6].rty !== 1'b1 || la[6].tid.tranid !== 4'd6 || la[6].adr !== 32'hFFF00010)
      begin errors++; $display("FAIL qfull_rty_c6: rty=%b tranid=%0d adr=%h want 1 6 fff00010", la[6].rty, la[6].tid.tranid, la[6].adr); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (la[5+5*k].ack !== 1'b1 || la[5+5*k].tid.tranid !== 4'(k + 1) || la[5+5*k].dat !== wd)
        begin errors++; $display("FAIL qfull_ack_c%0d: ack=%b tranid=%0d dat=%h want 1 %0d %h", 5+5*k, la[5+5*k].ack, la[5+5*k].tid.tranid, la[5+5*k].dat, k + 1, wd); end
    end
  endtask

  task automatic test_collision();
    int nr = 0;
    do_reset();
    for (int i = 0; i < 5; i++) sched[i] = mk(1'b0, '0, 32'hFFF00010, '0, 4'(i + 1));
    run(20);
    for (int c = 0; c < 20; c++) nr += int'(la[c].rty);
    checks++;
    if (nr != 0) begin errors++; $display("FAIL coll_q4_rty: got %0d want 0", nr); end
    checks++;
    if (lb[4].rty !== 1'b1 || lb[4].tid.tranid !== 4'd4 || lb[4].ack !== 1'b0)
      begin errors++; $display("FAIL coll_rty_c4: rty=%b tranid=%0d ack=%b want 1 4 0", lb[4].rty, lb[4].tid.tranid, lb[4].ack); end
    checks++;
    if (lb[5].rty !== 1'b1 || lb[5].tid.tranid !== 4'd5 || lb[5].ack !== 1'b0)
      begin errors++; $display("FAIL coll_rty_c5: rty=%b tranid=%0d ack=%b want 1 5 0", lb[5].rty, lb[5].tid.tranid, lb[5].ack); end
    checks++;
    if (lb[6].ack !== 1'b1 || lb[6].rty !== 1'b0 || lb[6].tid.tranid !== 4'd1)
      begin errors++; $display("FAIL coll_ack_c6: ack=%b rty=%b tranid=%0d want 1 0 1", lb[6].ack, lb[6].rty, lb[6].tid.tranid); end
    checks++;
    if (lb[11].ack !== 1'b1 || lb[11].tid.tranid !== 4'd2 || lb[10].ack !== 1'b0)
      begin errors++; $display("FAIL coll_ack_c11: ack=%b tranid=%0d early=%b want 1 2 0", lb[11].ack, lb[11].tid.tranid, lb[10].ack); end
  endtask

  task automatic test_miss();
    int n = 0;
    do_reset();
    sched[0]  = mk(1'b0, '0, 32'h00001000, '0, 4'd1);
    sched[12] = mk(1'b0, '0, 32'hFFF00010, '0, 4'd2);
    run(20);
    for (int c = 0; c < 12; c++) n += int'(la[c].ack) + int'(la[c].rty) + int'(lb[c].ack) + int'(lb[c].rty);
    checks++;
    if (n != 0) begin errors++; $display("FAIL miss_quiet: responses=%0d want 0", n); end
    checks++;
    if (la[17].ack !== 1'b1 || la[17].tid.tranid !== 4'd2 || lb[17].ack !== 1'b1)
      begin errors++; $display("FAIL miss_next_c17: ack_a=%b tranid=%0d ack_b=%b want 1 2 1", la[17].ack, la[17].tid.tranid, lb[17].ack); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    for (int i = 0; i < 3; i++) sched[i] = mk(1'b0, '0, 32'hFFF00010, '0, 4'(i + 1));
    run(5);
    @(posedge clk);
    #1;
    checks++;
    if (resp_a.ack !== 1'b1) begin errors++; $display("FAIL rstmid_pre_c5: ack=%b want 1", resp_a.ack); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (resp_a !== '0 || resp_b !== '0) begin errors++; $display("FAIL rstmid_async: a=%h b=%h want 0", resp_a, resp_b); end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_sched();
    run(15);
    for (int c = 0; c < 15; c++) n += int'(la[c].ack) + int'(lb[c].ack);
    checks++;
    if (n != 0) begin errors++; $display("FAIL rstmid_abandon: acks=%0d want 0", n); end
    sched[0] = mk(1'b0, '0, 32'hFFF00010, '0, 4'd4);
    run(8);
    checks++;
    if (la[5].ack !== 1'b1 || la[5].tid.tranid !== 4'd4 || la[4].ack !== 1'b0)
      begin errors++; $display("FAIL rstmid_next_c5: ack=%b tranid=%0d early=%b want 1 4 0", la[5].ack, la[5].tid.tranid, la[4].ack); end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t cur;
    int remain = 0;
    bit pend = 0, pknown = 0, rs = 0, hit, rej, ackn, popn;
    logic [127:0] pdat, v;
    fta_tranid_t ptid, rtid;
    logic [31:0] padr, radr;
    logic [127:0] mm [int];
    fta_cmd_request128_t r;
    int ln, k;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      ackn = pend && !rs;
      checks++;
      if (resp_a.ack !== ackn || resp_a.rty !== rs || resp_a.err !== 1'b0)
        begin errors++; $display("FAIL rnd_hs c%0d: ack=%b rty=%b err=%b want %b %b 0", c, resp_a.ack, resp_a.rty, resp_a.err, ackn, rs); end
      if (rs) begin
        checks++;
        if (resp_a.tid !== rtid || resp_a.adr !== radr)
          begin errors++; $display("FAIL rnd_rty c%0d: tid=%h adr=%h want %h %h", c, resp_a.tid, resp_a.adr, rtid, radr); end
      end
      if (ackn) begin
        checks++;
        if (resp_a.tid !== ptid || resp_a.adr !== padr || (pknown && resp_a.dat !== pdat))
          begin errors++; $display("FAIL rnd_ack c%0d: tid=%h adr=%h dat=%h want %h %h %h", c, resp_a.tid, resp_a.adr, resp_a.dat, ptid, padr, pdat); end
      end
      r = '0;
      k = $urandom_range(0, 9);
      if (c < 540 && k < 7) begin
        r = mk(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 16'hffff : 16'($urandom),
               {12'hFFF, 3'b000, 1'($urandom_range(0, 1)), 8'h00, 4'($urandom_range(0, 7)), 4'($urandom)},
               {$urandom, $urandom, $urandom, $urandom}, 4'($urandom));
        if (k == 5) r.adr = 32'h00001000 | 32'($urandom_range(0, 255));
        if (k == 6) r.stb = 1'b0;
      end
      req = r;
      hit  = r.cyc && r.stb && ((r.adr & 32'hFFF00000) == 32'hFFF00000);
      rej  = hit && q.size() >= QD;
      popn = remain == 0 && q.size() > 0 && !pend;
      if (ackn) pend = 0;
      if (popn) begin
        cur = q.pop_front();
        remain = ACC;
      end else if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          ln = int'(cur.adr[15:4]);
          if (cur.we) begin
            if (mm.exists(ln)) begin
              v = mm[ln];
              for (int b = 0; b < 16; b++) if (cur.sel[b]) v[b*8 +: 8] = cur.dat[b*8 +: 8];
              mm[ln] = v;
            end else if (cur.sel == 16'hffff) mm[ln] = cur.dat;
          end
          pknown = mm.exists(ln);
          if (pknown) pdat = mm[ln];
          ptid = cur.tid;
          padr = cur.adr;
          pend = 1;
        end
      end
      if (hit && !rej) q.push_back('{r.we, r.sel, r.adr, r.dat, r.tid});
      rs = rej;
      if (rej) begin rtid = r.tid; radr = r.adr; end
    end
  endtask

  initial begin
    req = '0;
    test_reset();
    test_write_read();
    test_byte_merge();
    test_queue_full();
    test_collision();
    test_miss();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
